fp32_div_issue_ctrl: RTL and testbench

Issue and sequencing stage placed directly in front of the iterative radix-4 SRT FP32 divider datapath. It accepts operand pairs over a valid/ready handshake and resolves IEEE special cases without using the datapath. For normal operands it holds the operands stable, pulses the divider's active-low load/reset, counts the iterations, and captures the rounded quotient. The result is presented on a valid/ready output port.

---
 rtl/fp32_div_pkg.sv | 36 +++
 rtl/fp32_special_classify.sv | 53 +++++
 rtl/fp32_div_issue_ctrl.sv | 118 +++++++++++
 tb/tb_fp32_div_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_div_pkg.sv
// fp32_div_pkg
//   Shared types and constants for the FP32 divider issue stage:
//   FSM state encoding, default iteration count, IEEE special encodings,
//   and an operand classification helper used by the special-case logic.
package fp32_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int          ITERS_DEFAULT = 13;
  localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_ZERO   = 32'h8000_0000;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic sign;
  } class_t;

  // Denormals (exponent 0, nonzero mantissa) are flushed to a signed zero.
  function automatic class_t classify(input logic [31:0] x);
    class_t c;
    c.sign    = x[31];
    c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    c.is_zero = (x[30:23] == 8'h00);
    return c;
  endfunction

endpackage

// File: rtl/fp32_special_classify.sv
// fp32_special_classify
//   Purely combinational IEEE special-case resolver for FP32 division.
//   Ports:
//     dividend, divisor : FP32 operands
//     special           : operands need no datapath; result is final
//     result            : bypass result (valid when special=1)
//     nv, dz            : invalid-operation / divide-by-zero flags
module fp32_special_classify
  import fp32_div_pkg::*;
#(
  parameter logic [31:0] QNAN = FP_QNAN
) (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        special,
  output logic [31:0] result,
  output logic        nv,
  output logic        dz
);

  class_t      a;
  class_t      b;
  logic [31:0] sign_bit;

  assign a        = classify(dividend);
  assign b        = classify(divisor);
  assign sign_bit = (a.sign ^ b.sign) ? FP_NEG_ZERO : 32'd0;

  // NOTE: every output gets a default before the decision tree so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    special = 1'b1;
    result  = 32'd0;
    nv      = 1'b0;
    dz      = 1'b0;
    if (a.is_nan || b.is_nan || (a.is_zero && b.is_zero) ||
        (a.is_inf && b.is_inf)) begin
      result = QNAN;
      nv     = 1'b1;
    end else if (b.is_zero) begin
      // inf/0 is an exact infinity, only finite/0 raises divide-by-zero.
      result = FP_POS_INF | sign_bit;
      dz     = !a.is_inf;
    end else if (a.is_inf) begin
      result = FP_POS_INF | sign_bit;
    end else if (a.is_zero || b.is_inf) begin
      result = sign_bit;
    end else begin
      special = 1'b0;
    end
  end

endmodule

// File: rtl/fp32_div_issue_ctrl.sv
// fp32_div_issue_ctrl
//   Issue/sequencing stage in front of an iterative radix-4 SRT FP32 divider.
//   Special operands are resolved locally; normal operands are held on the
//   divider inputs, the divider is pulsed through its active-low load/reset,
//   ITERS iterations are counted and the quotient is captured.
//   Ports:
//     clk, rst                      : clock, asynchronous active-low reset
//     in_valid/in_ready             : operand handshake (ready == IDLE)
//     in_dividend, in_divisor       : FP32 operands
//     div_dividend, div_divisor     : registered operands to the divider
//     div_rst                       : registered active-low divider load/reset
//     div_quotient                  : divider quotient
//     out_valid/out_ready           : result handshake
//     out_quotient, out_flags       : result and {nv, dz, bypass}
module fp32_div_issue_ctrl
  import fp32_div_pkg::*;
#(
  parameter int          ITERS = ITERS_DEFAULT,
  parameter logic [31:0] QNAN  = FP_QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_rst,
  input  logic [31:0] div_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quotient,
  output logic [2:0]  out_flags
);

  localparam logic [3:0] ITERS_CNT = 4'(ITERS);

  state_t      state;
  logic [3:0]  cnt;
  logic        sp_special;
  logic [31:0] sp_result;
  logic        sp_nv;
  logic        sp_dz;

  fp32_special_classify #(
    .QNAN(QNAN)
  ) u_classify (
    .dividend(in_dividend),
    .divisor (in_divisor),
    .special (sp_special),
    .result  (sp_result),
    .nv      (sp_nv),
    .dz      (sp_dz)
  );

  assign in_ready = (state == S_IDLE);

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: every register, including the operand and result words, is in the
  // async reset so an aborted operation leaves nothing visible downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      div_rst      <= 1'b0;
      out_valid    <= 1'b0;
      out_quotient <= 32'd0;
      out_flags    <= 3'b000;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
            if (sp_special) begin
              out_quotient <= sp_result;
              out_flags    <= {sp_nv, sp_dz, 1'b1};
              out_valid    <= 1'b1;
              state        <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        // div_rst was low through IDLE and stays low this one cycle with the
        // operands already stable, which loads the divider.
        S_LOAD: begin
          cnt     <= 4'd0;
          div_rst <= 1'b1;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (cnt == ITERS_CNT) begin
            out_quotient <= div_quotient;
            out_flags    <= 3'b000;
            out_valid    <= 1'b1;
            div_rst      <= 1'b0;
            state        <= S_DONE;
          end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_issue_ctrl.sv
// tb_fp32_div_issue_ctrl
//   Directed bench for the FP32 divider issue stage. The divider itself is
//   stood in for by a constant quotient on div_quotient.
module tb_fp32_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_rst;
  logic [31:0] div_quotient;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic [2:0]  out_flags;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] SIX   = 32'h40C0_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] ONE   = 32'h3F80_0000;

  fp32_div_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_rst     (div_rst),
    .div_quotient(div_quotient),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quotient(out_quotient),
    .out_flags   (out_flags)
  );

  always #5 clk = ~clk;

  // Offer one operand pair, then watch the negedges after the accepting
  // edge. exp_lat counts edges after the accepting edge until out_valid is
  // seen: 0 for bypass (registered on the accepting edge), 15 for normal.
  task automatic run_op(input string name, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_q, input logic [2:0] exp_f,
                        input int exp_hi);
    int lat;
    int hi;
    bit ops_ok;
    lat    = -1;
    hi     = 0;
    ops_ok = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready before offer: got %b want 1", name, in_ready);
    else n_pass++;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    @(negedge clk);
    in_valid    = 1'b0;
    in_dividend = 32'd0;
    in_divisor  = 32'd0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (div_dividend !== a || div_divisor !== b) ops_ok = 1'b0;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (div_rst === 1'b1) hi++;
    end
    n_total++;
    if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (out_quotient !== exp_q) $display("FAIL %s quotient: got %h want %h", name, out_quotient, exp_q);
    else n_pass++;
    n_total++;
    if (out_flags !== exp_f) $display("FAIL %s flags: got %b want %b", name, out_flags, exp_f);
    else n_pass++;
    n_total++;
    if (hi != exp_hi) $display("FAIL %s div_rst high cycles: got %0d want %0d", name, hi, exp_hi);
    else n_pass++;
    n_total++;
    if (!ops_ok) $display("FAIL %s operands unstable: got %h/%h want %h/%h", name, div_dividend, div_divisor, a, b);
    else n_pass++;
    n_total++;
    if (div_rst !== 1'b0) $display("FAIL %s div_rst in DONE: got %b want 0", name, div_rst);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s after handshake: got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if (div_rst !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset ctrl: got div_rst=%b valid=%b ready=%b want 0 0 1", div_rst, out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (out_quotient !== 32'd0 || out_flags !== 3'b000 || div_dividend !== 32'd0 || div_divisor !== 32'd0)
      $display("FAIL reset data: got q=%h f=%b dd=%h dv=%h want zeros", out_quotient, out_flags, div_dividend, div_divisor);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_normal();
    run_op("six_by_two", SIX, TWO, 15, THREE, 3'b000, 14);
  endtask

  task automatic test_specials();
    run_op("one_by_zero", ONE, 32'h0000_0000, 0, 32'h7F80_0000, 3'b011, 0);
    run_op("zero_by_zero", 32'h0000_0000, 32'h8000_0000, 0, 32'h7FC0_0000, 3'b101, 0);
    run_op("inf_by_inf", 32'h7F80_0000, 32'hFF80_0000, 0, 32'h7FC0_0000, 3'b101, 0);
    run_op("nan_by_one", 32'h7FC0_0001, ONE, 0, 32'h7FC0_0000, 3'b101, 0);
    run_op("neg_one_by_inf", 32'hBF80_0000, 32'h7F80_0000, 0, 32'h8000_0000, 3'b001, 0);
    run_op("denorm_by_two", 32'h0000_0001, TWO, 0, 32'h0000_0000, 3'b001, 0);
    run_op("neg_inf_by_two", 32'hFF80_0000, TWO, 0, 32'hFF80_0000, 3'b001, 0);
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  stable_ok;
    bit  ready_ok;
    lat       = -1;
    stable_ok = 1'b1;
    ready_ok  = 1'b1;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = SIX;
    in_divisor  = TWO;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_total++;
    if (lat != 15) $display("FAIL bp latency: got %0d want 15", lat);
    else n_pass++;
    // Offer 1.0/0 while the result is held; it must wait for the handshake.
    in_valid    = 1'b1;
    in_dividend = ONE;
    in_divisor  = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_quotient !== THREE || out_flags !== 3'b000) stable_ok = 1'b0;
      if (in_ready !== 1'b0) ready_ok = 1'b0;
    end
    n_total++;
    if (!stable_ok) $display("FAIL bp result hold: got v=%b q=%h f=%b want 1 %h 000", out_valid, out_quotient, out_flags, THREE);
    else n_pass++;
    n_total++;
    if (!ready_ok) $display("FAIL bp in_ready during hold: got %b want 0", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp handshake: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_quotient !== 32'h7F80_0000 || out_flags !== 3'b011)
      $display("FAIL bp queued op: got v=%b q=%h f=%b want 1 7f800000 011", out_valid, out_quotient, out_flags);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit quiet_ok;
    quiet_ok = 1'b1;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = SIX;
    in_divisor  = TWO;
    @(negedge clk);
    in_valid = 1'b0;
    // Negedge k+1 after the accepting edge sees cnt == k; stop at cnt == 7.
    repeat (8) @(negedge clk);
    n_total++;
    if (div_rst !== 1'b1) $display("FAIL midrun div_rst before reset: got %b want 1", div_rst);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (div_rst !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrun async reset: got div_rst=%b valid=%b ready=%b want 0 0 1", div_rst, out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (out_quotient !== 32'd0 || out_flags !== 3'b000 || div_dividend !== 32'd0 || div_divisor !== 32'd0)
      $display("FAIL midrun data clear: got q=%h f=%b dd=%h dv=%h want zeros", out_quotient, out_flags, div_dividend, div_divisor);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_rst !== 1'b0) quiet_ok = 1'b0;
    end
    n_total++;
    if (!quiet_ok) $display("FAIL midrun post-release idle: got valid=%b ready=%b div_rst=%b want 0 1 0", out_valid, in_ready, div_rst);
    else n_pass++;
    run_op("six_by_two_after_reset", SIX, TWO, 15, THREE, 3'b000, 14);
  endtask

  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_dividend  = 32'd0;
    in_divisor   = 32'd0;
    out_ready    = 1'b0;
    div_quotient = THREE;
    repeat (2) @(negedge clk);
    test_reset();
    test_normal();
    test_specials();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
